// File: rtl/serial_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [31:0] REG_DATA     = 32'h0;
  localparam logic [31:0] REG_STATUS   = 32'h4;
  localparam int          REG_ADDR_BIT = 2;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = STAT_OVF + 1;

  function automatic logic [31:0] pack_status(input logic [4:0] count5,
                                              input logic       ovf,
                                              input logic       busy,
                                              input logic       empty,
                                              input logic       full);
    logic [31:0] s;
    s                        = '0;
    s[STAT_FULL]             = full;
    s[STAT_EMPTY]            = empty;
    s[STAT_BUSY]             = busy;
    s[STAT_OVF]              = ovf;
    s[STAT_COUNT_LSB +: 5]   = count5;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head (no read latency). Pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-mapped UART transmitter: DATA pushes bytes into a FIFO, STATUS reports
// count/ovf/busy/empty/full. Define SERIAL_PARITY_EN for 8E1 frames (default 8N1).
module uart_tx_fifo
  import serial_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
`ifdef SERIAL_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          wr_data, rd_status, pop, full, empty, baud_end;
  logic [7:0]    head;
  logic [PW-1:0] count;
  logic [31:0]   count_w;
  logic [4:0]    count5;
  logic          unused_bits;

  assign wr_data     = sel & we & ~addr[REG_ADDR_BIT];
  assign rd_status   = sel & re & addr[REG_ADDR_BIT];
  assign unused_bits = ^{addr[31:3], addr[1:0], din[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (clrn),
    .push_i  (wr_data),
    .pop_i   (pop),
    .wdata_i (din[7:0]),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // A rejected push and a STATUS read on the same edge leave ovf set.
  always_comb begin
    ovf_d = ovf_q;
    if (rd_status)       ovf_d = 1'b0;
    if (wr_data && full) ovf_d = 1'b1;
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SERIAL_PARITY_EN
  // Parity is taken from the whole byte at pop time, before shifting consumes it.
  assign parity_d = pop ? ^head : parity_q;
`endif

  // tx is registered from the next state, so the line changes on the state edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign count_w = 32'(count);
  assign count5  = (count_w > 32'd31) ? 5'd31 : count_w[4:0];

  always_comb begin
    dout = 32'd0;
    if (addr[REG_ADDR_BIT]) begin
      dout = pack_status(count5, ovf_q, state_q != ST_IDLE, empty, full);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model compared
// every cycle, directed frame/overflow/reset scenarios, then random bus traffic.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 8;
  localparam int BAUD   = 1;
  localparam int DIV    = 8;
  localparam int DEPTH  = 16;
`ifdef SERIAL_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic        clock = 1'b0;
  logic        clrn, sel, we, re, tx;
  logic [31:0] addr, din, dout;

  int checks = 0;
  int errors = 0;

  logic txs [0:255];
  logic bsy [0:255];

  always #5 clock = ~clock;

  uart_tx_fifo #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clock (clock),
    .clrn  (clrn),
    .sel   (sel),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .tx    (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "cycles into the current frame".
  logic [7:0] mq [$];
  bit         m_ovf, m_inf, m_full_pre, m_wr, m_rd;
  int         m_t;
  logic [7:0] m_cur;

  initial begin
    forever begin
      @(posedge clock or negedge clrn);
      if (!clrn) begin
        mq.delete();
        m_ovf = 0;
        m_inf = 0;
        m_t   = 0;
      end else begin
        m_wr       = sel && we && !addr[2];
        m_rd       = sel && re && addr[2];
        m_full_pre = (mq.size() == DEPTH);
        if (m_inf) begin
          m_t++;
          if (m_t == FRAME) m_inf = 0;
        end else if (mq.size() != 0) begin
          m_cur = mq.pop_front();
          m_inf = 1;
          m_t   = 0;
        end
        if (m_rd) m_ovf = 0;
        if (m_wr) begin
          if (!m_full_pre) mq.push_back(din[7:0]);
          else             m_ovf = 1;
        end
      end
    end
  end

  function automatic logic m_tx();
    int k;
    if (!m_inf) return 1'b1;
    k = m_t / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
`ifdef SERIAL_PARITY_EN
    if (k == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_dout(input logic a2);
    int n;
    int c;
    if (!a2) return 32'd0;
    n = mq.size();
    c = (n > 31) ? 31 : n;
    return (32'(c) << 4) | (32'(m_ovf) << 3) | (32'(m_inf) << 2) |
           (32'(n == 0) << 1) | 32'(n == DEPTH);
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      check("tx_cycle", {31'd0, tx}, {31'd0, m_tx()});
      check("dout_cycle", dout, m_dout(addr[2]));
    end
  end

  task automatic idle_inputs();
    sel  = 1'b0;
    we   = 1'b0;
    re   = 1'b0;
    addr = 32'h4;
    din  = 32'h0;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cycle_write(input logic [7:0] b);
    sel  = 1'b1;
    we   = 1'b1;
    re   = 1'b0;
    addr = 32'h0;
    din  = {24'($urandom), b};
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] exp);
    @(negedge clock);
    check(name, dout, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input int n, input bit second, input logic [7:0] b2);
    if (second) begin
      sel  = 1'b1;
      we   = 1'b1;
      re   = 1'b0;
      addr = 32'h0;
      din  = {24'h0, b2};
    end else begin
      idle_inputs();
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      txs[i] = tx;
      bsy[i] = dout[2];
      @(posedge clock);
      #1;
      idle_inputs();
    end
  endtask

  task automatic check_frame(input string tag, input logic [10:0] e);
    int busy_cnt;
    busy_cnt = 0;
    check({tag, "_pre_start"}, {31'd0, txs[0]}, 32'd1);
    for (int k = 0; k < NBITS; k++) begin
      logic v;
      bit   uni;
      v   = txs[1 + k*DIV];
      uni = 1'b1;
      for (int j = 0; j < DIV; j++) begin
        if (txs[1 + k*DIV + j] !== v) uni = 1'b0;
      end
      check($sformatf("%s_bit%0d", tag, k), {30'd0, uni, v}, {30'd0, 1'b1, e[k]});
    end
    check({tag, "_idle_after"}, {31'd0, txs[1 + FRAME]}, 32'd1);
    for (int i = 0; i < FRAME + 20; i++) busy_cnt += int'(bsy[i]);
    check({tag, "_busy_cycles"}, busy_cnt, FRAME);
  endtask

  task automatic wait_drain(input string name, input int bound);
    bit done;
    done = 1'b0;
    idle_inputs();
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (dout[2] == 1'b0 && dout[1] == 1'b1) begin
        done = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (done) begin
      @(posedge clock);
      #1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int r1, r2, lows, bcnt;
    idle_inputs();
    clrn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_status", dout, 32'h2);
    check("reset_tx", {31'd0, tx}, 32'd1);
    clrn = 1'b1;
    idle_cycles(4);

    // Single 0x55 frame: start, LSB-first data, (parity 0), stop.
    cycle_write(8'h55);
    capture(FRAME + 20, 1'b0, 8'h0);
`ifdef SERIAL_PARITY_EN
    check_frame("frame55", {1'b1, 1'b0, 8'h55, 1'b0});
`else
    check_frame("frame55", {1'b0, 1'b1, 8'h55, 1'b0});
`endif

    // 17 back-to-back writes fill the FIFO exactly; the 18th overflows.
    for (int i = 0; i < 17; i++) cycle_write(8'(i * 13 + 1));
    idle_inputs();
    peek("burst_full_status", 32'h105);
    cycle_write(8'hEE);
    idle_inputs();
    peek("ovf_set_status", 32'h10D);
    sel = 1'b1;
    re  = 1'b1;
    peek("ovf_read_preclear", 32'h10D);
    idle_inputs();
    peek("ovf_after_clear", 32'h105);
    wait_drain("burst_drain", 3000);

    // Two consecutive writes: second start bit exactly one frame plus one IDLE later.
    cycle_write(8'hA5);
    capture(200, 1'b1, 8'h3C);
    r1 = -1;
    r2 = -1;
    for (int i = 1; i < 200; i++) begin
      if (bsy[i] && !bsy[i-1]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    check("b2b_first_start", r1, 1);
    check("b2b_start_gap", r2 - r1, FRAME + 1);
    check("b2b_second_start_low", {31'd0, txs[(r2 < 0) ? 0 : r2]}, 32'd0);
    wait_drain("b2b_drain", 400);

    // Reset in the middle of DATA bit 3 of an all-zero byte.
    cycle_write(8'h00);
    idle_cycles(35);
    check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    #2;
    clrn = 1'b0;
    #1;
    check("mid_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_reset_status", dout, 32'h2);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    clrn = 1'b1;
    capture(120, 1'b0, 8'h0);
    lows = 0;
    bcnt = 0;
    for (int i = 0; i < 120; i++) begin
      lows += int'(!txs[i]);
      bcnt += int'(bsy[i]);
    end
    check("post_reset_tx_lows", lows, 0);
    check("post_reset_busy", bcnt, 0);

`ifdef SERIAL_PARITY_EN
    cycle_write(8'h07);
    capture(FRAME + 20, 1'b0, 8'h0);
    check_frame("frame07", {1'b1, 1'b1, 8'h07, 1'b0});
`endif

    // Random bus traffic at three write densities.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1200; i++) begin
        int          r;
        int          wr_pct;
        logic [31:0] a;
        wr_pct = (p == 0) ? 2 : ((p == 1) ? 6 : 12);
        r = $urandom_range(0, 99);
        a = $urandom;
        idle_inputs();
        if (r < wr_pct) begin
          sel = 1'b1; we = 1'b1; addr = {a[31:3], 1'b0, a[1:0]}; din = $urandom;
        end else if (r < wr_pct + 3) begin
          sel = 1'b1; we = 1'b1; addr = {a[31:3], 1'b1, a[1:0]}; din = $urandom;
        end else if (r < wr_pct + 8) begin
          sel = 1'b0; we = 1'b1; re = 1'($urandom_range(0, 1)); addr = a; din = $urandom;
        end else if (r < wr_pct + 13) begin
          sel = 1'b1; re = 1'b1; addr = {a[31:3], 1'b1, a[1:0]};
        end else if (r < wr_pct + 16) begin
          sel = 1'b1; re = 1'b1; addr = {a[31:3], 1'b0, a[1:0]};
        end else begin
          addr = a;
        end
        @(posedge clock);
        #1;
      end
    end
    wait_drain("random_drain", 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
